// File: rtl/caliptra_apb_init_pkg.sv
// Shared types and constants for caliptra_apb_initiator.
// Bus widths come from CALIPTRA_APB_{ADDR,DATA,USER}_WIDTH and default to 32 bits.
`ifndef CALIPTRA_APB_ADDR_WIDTH
`define CALIPTRA_APB_ADDR_WIDTH 32
`endif
`ifndef CALIPTRA_APB_DATA_WIDTH
`define CALIPTRA_APB_DATA_WIDTH 32
`endif
`ifndef CALIPTRA_APB_USER_WIDTH
`define CALIPTRA_APB_USER_WIDTH 32
`endif

package caliptra_apb_init_pkg;

  localparam int unsigned APB_ADDR_W = `CALIPTRA_APB_ADDR_WIDTH;
  localparam int unsigned APB_DATA_W = `CALIPTRA_APB_DATA_WIDTH;
  localparam int unsigned APB_USER_W = `CALIPTRA_APB_USER_WIDTH;

  localparam logic [2:0] APB_PPROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_init_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_USER_W-1:0] user;
  } apb_init_req_t;

  // Only word-aligned accesses are issued on the bus.
  function automatic logic is_misaligned(input logic [APB_ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/caliptra_apb_init_fifo.sv
// Synchronous request queue for caliptra_apb_initiator. Pointers carry an extra
// wrap bit so full and empty are distinguished without an occupancy counter.
module caliptra_apb_init_fifo
  import caliptra_apb_init_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter type         item_t = apb_init_req_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  item_t wdata_i,
  output logic  full_o,
  input  logic  pop_i,
  output item_t rdata_o,
  output logic  empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  item_t            mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // A full queue refuses the push even when the head is popped the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it
  // has been written, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/caliptra_apb_initiator.sv
// Queued APB requester for Caliptra's APB slave port: one transfer and one
// in-order response per request. CALIPTRA_APB_INIT_TIMEOUT_EN adds a PREADY wait limit.
module caliptra_apb_initiator
  import caliptra_apb_init_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned USER_W      = APB_USER_W,
  parameter int unsigned FIFO_DEPTH  = 4
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 256
`endif
) (
  input  logic              clk,
  input  logic              cptra_rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [USER_W-1:0] req_user,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [USER_W-1:0] pauser,
  output logic [2:0]        pprot,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  apb_init_state_e   state_q, state_d;
  apb_init_req_t     req_in, head, cur_q, cur_d;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_to_q, rsp_to_d;
  logic              apb_active;
  logic              to_hit;

  assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata, user: req_user};

  caliptra_apb_init_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .item_t (apb_init_req_t)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (cptra_rst_b),
    .push_i  (req_valid),
    .wdata_i (req_in),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .empty_o (fifo_empty)
  );

`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // The cycle that would bring the count to TIMEOUT_CYC ends the transfer.
  assign to_hit = (state_q == ACCESS) && !pready &&
                  (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == SETUP) begin
      to_cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready && !to_hit) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) to_cnt_q <= '0;
    else              to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // NOTE: every signal written here gets its default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_misaligned(head.addr)) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_to_d    = 1'b0;
          end else begin
            cur_d   = head;
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_d     = RESP;
          rsp_rdata_d = (!cur_q.write && !pslverr) ? prdata : '0;
          rsp_err_d   = pslverr;
          rsp_to_d    = 1'b0;
        end else if (to_hit) begin
          state_d     = RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  // Bus outputs are gated by state, so an async reset drops them immediately.
  assign apb_active = (state_q == SETUP) || (state_q == ACCESS);
  assign psel       = apb_active;
  assign penable    = (state_q == ACCESS);
  assign paddr      = apb_active ? cur_q.addr : '0;
  assign pwrite     = apb_active && cur_q.write;
  assign pwdata     = (apb_active && cur_q.write) ? cur_q.wdata : '0;
  assign pauser     = apb_active ? cur_q.user : '0;
  assign pprot      = APB_PPROT_DEFAULT;

  assign req_ready   = !fifo_full;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
  assign rsp_timeout = rsp_to_q;
`else
  assign rsp_timeout = 1'b0;
`endif
  assign busy        = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_caliptra_apb_initiator.sv
// Directed testbench for caliptra_apb_initiator: vector table for single
// transfers plus hand-written queue-full, timeout and reset sequences.
module tb_caliptra_apb_initiator;
  import caliptra_apb_init_pkg::*;

  localparam int unsigned AW = APB_ADDR_W;
  localparam int unsigned DW = APB_DATA_W;
  localparam int unsigned UW = APB_USER_W;

  logic          clk = 1'b0;
  logic          cptra_rst_b;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [UW-1:0] req_user;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable, pready, pslverr, busy;
  logic [DW-1:0] pwdata, prdata;
  logic [UW-1:0] pauser;
  logic [2:0]    pprot;

  // Bench-side APB completer: either auto-ready with address-derived data or manual.
  logic          auto_rsp;
  logic          pready_man, pslverr_man;
  logic [31:0]   prdata_man;
  assign pready  = auto_rsp ? 1'b1 : pready_man;
  assign pslverr = auto_rsp ? 1'b0 : pslverr_man;
  assign prdata  = auto_rsp ? DW'({16'hBEEF, paddr[15:0]}) : DW'(prdata_man);

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  caliptra_apb_initiator dut (
    .clk         (clk),
    .cptra_rst_b (cptra_rst_b),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_user    (req_user),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .pauser      (pauser),
    .pprot       (pprot),
    .psel        (psel),
    .penable     (penable),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input string name, input int limit);
    int n = 0;
    while (!rsp_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rsp_valid"}, 64'(rsp_valid), 64'(1));
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] user;
    int unsigned wait_cyc;
    logic [31:0] prdata;
    logic        pslverr;
    logic        exp_apb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // One request through IDLE -> SETUP -> ACCESS(wait_cyc+1) -> RESP, checked cycle by cycle.
  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] exp_pwdata;
    exp_pwdata = v.write ? v.wdata : 32'h0;
    req_write = v.write;
    req_addr  = AW'(v.addr);
    req_wdata = DW'(v.wdata);
    req_user  = UW'(v.user);
    req_valid = 1'b1;
    check($sformatf("v%0d_req_ready", idx), 64'(req_ready), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
    check($sformatf("v%0d_idle_psel", idx), 64'(psel), 64'(0));
    if (!v.exp_apb) begin
      @(negedge clk);
      check($sformatf("v%0d_misalign_psel", idx), 64'(psel), 64'(0));
    end else begin
      @(negedge clk);
      check($sformatf("v%0d_setup_sel_en", idx), 64'({psel, penable}), 64'(2'b10));
      check($sformatf("v%0d_setup_paddr", idx), 64'(paddr), 64'(v.addr));
      check($sformatf("v%0d_setup_pwrite", idx), 64'(pwrite), 64'(v.write));
      check($sformatf("v%0d_setup_pwdata", idx), 64'(pwdata), 64'(exp_pwdata));
      check($sformatf("v%0d_setup_pauser", idx), 64'(pauser), 64'(v.user));
      for (int c = 0; c <= int'(v.wait_cyc); c++) begin
        @(negedge clk);
        check($sformatf("v%0d_access%0d_sel_en", idx, c), 64'({psel, penable}), 64'(2'b11));
        check($sformatf("v%0d_access%0d_paddr", idx, c), 64'(paddr), 64'(v.addr));
        check($sformatf("v%0d_access%0d_pwdata", idx, c), 64'(pwdata), 64'(exp_pwdata));
        check($sformatf("v%0d_access%0d_rsp_valid", idx, c), 64'(rsp_valid), 64'(0));
        if (c == int'(v.wait_cyc)) begin
          pready_man  = 1'b1;
          prdata_man  = v.prdata;
          pslverr_man = v.pslverr;
        end
      end
      @(negedge clk);
      pready_man  = 1'b0;
      pslverr_man = 1'b0;
      prdata_man  = 32'h0;
      check($sformatf("v%0d_resp_psel", idx), 64'(psel), 64'(0));
    end
    check($sformatf("v%0d_rsp_valid", idx), 64'(rsp_valid), 64'(1));
    check($sformatf("v%0d_rsp_err", idx), 64'(rsp_err), 64'(v.exp_err));
    check($sformatf("v%0d_rsp_rdata", idx), 64'(rsp_rdata), 64'(v.exp_rdata));
    check($sformatf("v%0d_rsp_timeout", idx), 64'(rsp_timeout), 64'(0));
    @(negedge clk);
    check($sformatf("v%0d_rsp_held", idx), 64'({rsp_valid, rsp_rdata}), {31'h0, 1'b1, 32'(v.exp_rdata)});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d_done_rsp_valid", idx), 64'(rsp_valid), 64'(0));
    check($sformatf("v%0d_done_busy", idx), 64'(busy), 64'(0));
  endtask

  vec_t vecs[7];
  logic [31:0] exp_fill[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cptra_rst_b = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_user = '0;
    rsp_ready = 1'b0; auto_rsp = 1'b0;
    pready_man = 1'b0; pslverr_man = 1'b0; prdata_man = 32'h0;

    //               wr    addr          wdata         user  wait prdata        err   apb   exp_rdata     exp_err
    vecs[0] = '{1'b1, 32'h3003_0000, 32'hDEAD_BEEF, 32'h11, 0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h3003_0004, 32'hFFFF_FFFF, 32'h22, 3, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h3003_0002, 32'h0,         32'h33, 0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1};
    vecs[3] = '{1'b1, 32'h3003_0008, 32'h0BAD_F00D, 32'h44, 1, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 32'h3003_000C, 32'h0,         32'h55, 0, 32'hAAAA_5555, 1'b1, 1'b1, 32'h0,         1'b1};
    vecs[5] = '{1'b0, 32'h3003_0010, 32'h0,         32'h66, 1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[6] = '{1'b1, 32'h3003_0013, 32'h5555_AAAA, 32'h77, 0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1};
    exp_fill = '{32'hBEEF_0000, 32'hBEEF_0004, 32'hBEEF_0008, 32'hBEEF_000C, 32'hBEEF_0010};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_psel_penable", 64'({psel, penable}), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_paddr", 64'(paddr), 64'(0));
    check("rst_pwdata", 64'(pwdata), 64'(0));
    check("rst_rsp_rdata_err", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'(0));
    cptra_rst_b = 1'b1;
    @(negedge clk);
    check("post_rst_pprot", 64'(pprot), 64'(0));

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Queue fill: 5 back-to-back reads; first is popped into the FSM, the other four fill the queue.
    auto_rsp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_write = 1'b0;
      req_addr  = AW'(32'h4000_0000 + 32'(4 * i));
      req_valid = 1'b1;
      check($sformatf("fill%0d_req_ready", i), 64'(req_ready), 64'(1));
      @(negedge clk);
    end
    req_addr = AW'(32'h4000_0014);
    check("fill_full_req_ready", 64'(req_ready), 64'(0));
    check("fill_busy", 64'(busy), 64'(1));
    @(negedge clk);
    check("fill_still_full", 64'(req_ready), 64'(0));
    req_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      wait_rsp($sformatf("fill_rsp%0d", j), 10);
      check($sformatf("fill_rsp%0d_rdata", j), 64'(rsp_rdata), 64'(exp_fill[j]));
      check($sformatf("fill_rsp%0d_err", j), 64'(rsp_err), 64'(0));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("fill_drained_rsp_valid", 64'(rsp_valid), 64'(0));
    check("fill_drained_busy", 64'(busy), 64'(0));
    auto_rsp = 1'b0;

    // PREADY held low
    req_write = 1'b0;
    req_addr  = AW'(32'h5000_0000);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (psel && penable) n++;
      else if (n > 0) break;
    end
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
    check("to_access_cycles", 64'(n), 64'(256));
    check("to_psel_dropped", 64'({psel, penable}), 64'(0));
    check("to_rsp_valid", 64'(rsp_valid), 64'(1));
    check("to_rsp_err", 64'(rsp_err), 64'(1));
    check("to_rsp_timeout", 64'(rsp_timeout), 64'(1));
    check("to_rsp_rdata", 64'(rsp_rdata), 64'(0));
`else
    check("noto_access_cycles", 64'(n), 64'(299));
    check("noto_psel_high", 64'({psel, penable}), 64'(2'b11));
    check("noto_rsp_valid", 64'(rsp_valid), 64'(0));
    pready_man = 1'b1;
    prdata_man = 32'h600D_D00D;
    @(negedge clk);
    pready_man = 1'b0;
    check("noto_rsp_valid_after", 64'(rsp_valid), 64'(1));
    check("noto_rsp_rdata", 64'(rsp_rdata), 64'(32'h600D_D00D));
    check("noto_rsp_timeout", 64'(rsp_timeout), 64'(0));
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("to_done_busy", 64'(busy), 64'(0));

    // Reset during ACCESS with a second request queued behind it
    req_write = 1'b1;
    req_addr  = AW'(32'h3003_0020);
    req_wdata = DW'(32'h1111_2222);
    req_valid = 1'b1;
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = AW'(32'h3003_0024);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!penable && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_in_access", 64'(penable), 64'(1));
    cptra_rst_b = 1'b0;
    #1;
    check("rst_mid_psel_penable", 64'({psel, penable}), 64'(0));
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_mid_paddr", 64'(paddr), 64'(0));
    @(negedge clk);
    cptra_rst_b = 1'b1;
    @(negedge clk);
    check("rst_rel_req_ready", 64'(req_ready), 64'(1));
    check("rst_rel_busy", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);
    check("rst_rel_no_rsp", 64'({rsp_valid, psel}), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
